button_bit_encoder: RTL and testbench

Input stage that feeds the overlapping Moore sequence detector. It synchronizes and debounces the two push-buttons and encodes each accepted press as a single-clock serial bit: button[0] is bit 0 and button[1] is bit 1. It emits a one-cycle `bit_valid` strobe in the system clock domain, which the detector uses as its clock enable. This replaces the divided-clock pulse path with a fully synchronous one.

---
 rtl/button_bit_encoder.sv | 131 +++++++++++++
 tb/tb_button_bit_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_bit_encoder.sv
// Synchronizes and debounces two push-buttons, encoding each accepted press as a
// one-cycle bit strobe (button[0] -> 0, button[1] -> 1) in the system clock domain.
//
// state | meaning
// IDLE  | no debounced button held; waiting for a press
// HELD  | a press (or conflict) was handled; waiting for both buttons released
module button_bit_encoder #(
  parameter int TICK_DIV       = 524288,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] button,
  output logic       bit_valid,
  output logic       bit_data,
  output logic       conflict,
  output logic       busy,
  output logic [1:0] db_level,
  output logic [7:0] press_cnt
);

  localparam int              CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]      RUN_TGT   = 4'(STABLE_SAMPLES);

  typedef enum logic {IDLE, HELD} state_t;

  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [1:0][3:0]  run_q, run_d;
  logic [1:0]       db_q, db_d, db_prev_q, db_prev_d, rise_q, rise_d;
  state_t           state_q, state_d;
  logic             bit_valid_q, bit_valid_d, bit_data_q, bit_data_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  // Front end: synchronizer, tick divider, debounce and registered edge detect
  always_comb begin
    sync1_d    = button;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    db_d       = db_q;
    run_d      = run_q;
    for (int i = 0; i < 2; i++) begin
      if (tick) begin
        if (sync2_q[i] != db_q[i]) begin
          if (run_q[i] + 4'd1 == RUN_TGT) begin
            db_d[i]  = ~db_q[i];
            run_d[i] = '0;
          end else begin
            run_d[i] = run_q[i] + 4'd1;
          end
        end else begin
          run_d[i] = '0;
        end
      end
    end
    db_prev_d = db_q;
    rise_d    = db_q & ~db_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_valid_d = 1'b0;
    bit_data_d  = bit_data_q;
    conflict_d  = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (&rise_q) begin
          conflict_d = 1'b1;
          state_d    = HELD;
        end else if (rise_q[0] && !db_q[1]) begin
          bit_valid_d = 1'b1;
          bit_data_d  = 1'b0;
          state_d     = HELD;
        end else if (rise_q[1] && !db_q[0]) begin
          bit_valid_d = 1'b1;
          bit_data_d  = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (db_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Count alongside the strobe so press_cnt updates in the same edge as bit_valid
    if (bit_valid_d) press_cnt_d = press_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tick_cnt_q  <= '0;
      run_q       <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      rise_q      <= '0;
      state_q     <= IDLE;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      conflict_q  <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      run_q       <= run_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      rise_q      <= rise_d;
      state_q     <= state_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      conflict_q  <= conflict_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign conflict  = conflict_q;
  assign busy      = (state_q != IDLE);
  assign db_level  = db_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_button_bit_encoder.sv
// Directed bench for button_bit_encoder with TICK_DIV=4, STABLE_SAMPLES=3:
// a table of press/release vectors plus hand-written multi-cycle sequences.
module tb_button_bit_encoder;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] button;
  logic       bit_valid, bit_data, conflict, busy;
  logic [1:0] db_level;
  logic [7:0] press_cnt;

  button_bit_encoder #(.TICK_DIV(4), .STABLE_SAMPLES(3)) dut (
    .clk(clk), .clr(clr), .button(button),
    .bit_valid(bit_valid), .bit_data(bit_data), .conflict(conflict),
    .busy(busy), .db_level(db_level), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] btn;
    int         hold;
    int         exp_valid;
    logic       exp_data;
    int         exp_conf;
  } vec_t;

  vec_t vecs[5];
  int   tests = 0, fails = 0;
  int   nv, nc, cyc, first_lat, dbl = 0, exp_cnt = 0;
  logic last_data = 1'b0, prev_v = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    nv = 0; nc = 0; cyc = 0; first_lat = -1;
  endtask

  // Advance n cycles, sampling outputs on each falling edge
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (bit_valid) begin
        nv++;
        last_data = bit_data;
        if (first_lat < 0) first_lat = cyc;
        if (prev_v) dbl++;
      end
      if (conflict) nc++;
      prev_v = bit_valid;
    end
  endtask

  task automatic release_wait(input string name);
    int lat;
    lat = -1;
    button = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      run(1);
      if (lat < 0 && !busy) lat = k;
    end
    chk({name, "_busy_fall_le16"}, int'(lat >= 1 && lat <= 16), 1);
    chk({name, "_db_released"}, int'(db_level), 0);
  endtask

  initial begin
    vecs[0] = '{"press_b0",   2'b01, 60, 1, 1'b0, 0};
    vecs[1] = '{"press_b1",   2'b10, 60, 1, 1'b1, 0};
    vecs[2] = '{"press_both", 2'b11, 60, 0, 1'b0, 1};
    vecs[3] = '{"glitch_b0",  2'b01,  5, 0, 1'b0, 0};
    vecs[4] = '{"press_b1_2", 2'b10, 60, 1, 1'b1, 0};

    clr = 1'b0;
    button = 2'b00;
    clear_mon();
    run(3);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_bit_data",  int'(bit_data), 0);
    chk("rst_conflict",  int'(conflict), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_db_level",  int'(db_level), 0);
    chk("rst_press_cnt", int'(press_cnt), 0);
    clr = 1'b1;
    run(5);

    for (int i = 0; i < 5; i++) begin
      clear_mon();
      button = vecs[i].btn;
      run(vecs[i].hold);
      release_wait(vecs[i].name);
      exp_cnt = (exp_cnt + vecs[i].exp_valid) % 256;
      chk({vecs[i].name, "_valid_count"}, nv, vecs[i].exp_valid);
      chk({vecs[i].name, "_conflict_count"}, nc, vecs[i].exp_conf);
      chk({vecs[i].name, "_press_cnt"}, int'(press_cnt), exp_cnt);
      if (vecs[i].exp_valid > 0) begin
        chk({vecs[i].name, "_bit_data"}, int'(last_data), int'(vecs[i].exp_data));
        chk({vecs[i].name, "_latency_le16"}, int'(first_lat >= 1 && first_lat <= 16), 1);
      end
    end

    // Bounce: button[1] toggles every 3 cycles for 24 cycles, then stays high
    clear_mon();
    for (int t = 0; t < 8; t++) begin
      button = (t % 2 == 0) ? 2'b10 : 2'b00;
      run(3);
    end
    chk("bounce_no_early_bit", nv, 0);
    button = 2'b10;
    run(60);
    release_wait("bounce");
    exp_cnt++;
    chk("bounce_valid_count", nv, 1);
    chk("bounce_bit_data", int'(last_data), 1);
    chk("bounce_conflict", nc, 0);
    chk("bounce_press_cnt", int'(press_cnt), exp_cnt);

    // Overlap: second button pressed while first held is ignored
    clear_mon();
    button = 2'b01;
    run(30);
    button = 2'b11;
    run(60);
    chk("overlap_valid_count", nv, 1);
    chk("overlap_bit_data", int'(last_data), 0);
    chk("overlap_conflict", nc, 0);
    release_wait("overlap");
    clear_mon();
    button = 2'b10;
    run(60);
    chk("overlap2_valid_count", nv, 1);
    chk("overlap2_bit_data", int'(last_data), 1);
    release_wait("overlap2");
    exp_cnt += 2;
    chk("overlap_press_cnt", int'(press_cnt), exp_cnt);

    // Reset while busy with button[0] held
    clear_mon();
    button = 2'b01;
    for (int k = 0; k < 30; k++) begin
      run(1);
      if (busy) break;
    end
    chk("rmid_busy_before", int'(busy), 1);
    clr = 1'b0;
    #1;
    chk("rmid_bit_valid", int'(bit_valid), 0);
    chk("rmid_bit_data",  int'(bit_data), 0);
    chk("rmid_conflict",  int'(conflict), 0);
    chk("rmid_busy",      int'(busy), 0);
    chk("rmid_db_level",  int'(db_level), 0);
    chk("rmid_press_cnt", int'(press_cnt), 0);
    run(2);
    clr = 1'b1;
    clear_mon();
    run(30);
    chk("rmid_new_valid", nv, 1);
    chk("rmid_new_data", int'(last_data), 0);
    chk("rmid_latency_le16", int'(first_lat >= 1 && first_lat <= 16), 1);
    chk("rmid_press_cnt_after", int'(press_cnt), 1);
    release_wait("rmid");

    // Wrap: 256 clean presses from a freshly reset counter
    clr = 1'b0;
    run(2);
    clr = 1'b1;
    run(4);
    clear_mon();
    for (int p = 0; p < 256; p++) begin
      button = 2'b01;
      run(20);
      button = 2'b00;
      run(20);
      if (p == 254) chk("wrap_press_cnt_255", int'(press_cnt), 255);
    end
    chk("wrap_valid_count", nv, 256);
    chk("wrap_press_cnt_0", int'(press_cnt), 0);
    chk("wrap_conflict", nc, 0);
    chk("no_double_strobe", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
